// File: rtl/compare_arbiter.sv
// rtl/compare_arbiter.sv - round-robin arbiter sharing one magnitude comparator between two requesters
module compare_arbiter #(
   parameter int WIDTH     = 16,
   parameter bit RESET_PRI = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_signed,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_signed,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic             rsp_gt,
   output logic             rsp_lt,
   output logic             rsp_eq
);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

   // Pointer resets to the port that must lose the first tie.
   localparam logic L_LAST_RST = !RESET_PRI;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_signed;
   logic             r_id;
   logic             r_last;
   logic             r_gt;
   logic             r_lt;
   logic             r_eq;

   logic             w_open;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_eq;
   logic             w_lt;

   assign w_open = (r_state == S_IDLE) && !flush && reset_n;
   assign w_gnt0 = w_open && req0_valid && (!req1_valid || r_last);
   assign w_gnt1 = w_open && req1_valid && (!req0_valid || !r_last);

   assign w_eq = (r_a == r_b);
   assign w_lt = r_signed ? ($signed(r_a) < $signed(r_b)) : (r_a < r_b);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_gnt0 || w_gnt1) w_next = S_EVAL;
         S_EVAL: w_next = flush ? S_IDLE : S_RESP;
         S_RESP: if (flush || rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = w_gnt0;
      req1_ready = w_gnt1;
      rsp_valid  = (r_state == S_RESP);
      rsp_id     = r_id;
      rsp_gt     = r_gt;
      rsp_lt     = r_lt;
      rsp_eq     = r_eq;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_id     <= 1'b0;
         r_last   <= L_LAST_RST;
         r_gt     <= 1'b0;
         r_lt     <= 1'b0;
         r_eq     <= 1'b0;
      end else begin
         if (w_gnt0 || w_gnt1) begin
            r_a      <= w_gnt1 ? req1_a : req0_a;
            r_b      <= w_gnt1 ? req1_b : req0_b;
            r_signed <= w_gnt1 ? req1_signed : req0_signed;
            r_id     <= w_gnt1;
            r_last   <= w_gnt1;
         end
         // A flushed evaluation leaves the previous flags untouched; rsp_valid never exposes them.
         if (r_state == S_EVAL && !flush) begin
            r_eq <= w_eq;
            r_lt <= w_lt;
            r_gt <= !w_eq && !w_lt;
         end
      end
   end

endmodule

// File: tb/tb_compare_arbiter.sv
// tb/tb_compare_arbiter.sv - directed self-checking bench for compare_arbiter
module tb_compare_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        req0_valid, req0_ready, req0_signed;
   logic [15:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_signed;
   logic [15:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_gt, rsp_lt, rsp_eq;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   compare_arbiter #(.WIDTH(16), .RESET_PRI(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_signed(req0_signed),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_signed(req1_signed),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      flush = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_signed = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_signed = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   // Single request, then wait (bounded) for the response and hand it off.
   task automatic issue(input logic port, input logic [15:0] a, input logic [15:0] b,
                        input logic s, output logic acc, output logic found,
                        output logic [3:0] flags, output int lat);
      if (port) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_signed = s;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_signed = s;
      end
      rsp_ready = 1'b1;
      #1;
      acc = port ? (req1_ready && !req0_ready) : (req0_ready && !req1_ready);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      found = 1'b0; lat = 0; flags = 4'h0;
      for (int i = 1; i <= 8; i++) begin
         if (rsp_valid) begin
            found = 1'b1; lat = i;
            flags = {rsp_id, rsp_gt, rsp_lt, rsp_eq};
            break;
         end
         step();
      end
      if (found) step();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 1'b0;
      #3;
      n_vec++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected 0000000",
                  {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq});
      end
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single_port0();
      logic acc, found; logic [3:0] fl; int lat;
      issue(1'b0, 16'd3, 16'd2, 1'b0, acc, found, fl, lat);
      n_vec++;
      if ({acc, found} !== 2'b11) begin
         n_err++; $display("FAIL p0_handshake: got acc/found %b expected 11", {acc, found});
      end
      n_vec++;
      if (lat !== 2) begin
         n_err++; $display("FAIL p0_latency: got %0d expected 2", lat);
      end
      n_vec++;
      if (fl !== 4'b0100) begin
         n_err++; $display("FAIL p0_flags id/gt/lt/eq: got %b expected 0100", fl);
      end
      #1;
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL p0_valid_clear: got %b expected 0", rsp_valid);
      end
   endtask

   task automatic test_single_port1();
      logic acc, found; logic [3:0] fl; int lat;
      logic [15:0] va [3] = '{16'hFFFF, 16'hFFFF, 16'd40};
      logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'd40};
      logic        vs [3] = '{1'b1, 1'b0, 1'b0};
      logic [3:0]  ve [3] = '{4'b1010, 4'b1100, 4'b1001};
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, va[i], vb[i], vs[i], acc, found, fl, lat);
         n_vec++;
         if ({acc, found, fl} !== {2'b11, ve[i]}) begin
            n_err++;
            $display("FAIL p1_vec%0d acc/found/id/gt/lt/eq: got %b expected %b",
                     i, {acc, found, fl}, {2'b11, ve[i]});
         end
      end
   endtask

   task automatic test_round_robin();
      logic g;
      do_reset();
      req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd1;
      req1_valid = 1'b1; req1_a = 16'd1; req1_b = 16'd5;
      for (int cyc = 0; cyc < 12; cyc++) begin
         #1;
         g = ((cyc / 3) % 2) == 1;
         if (cyc % 3 == 0) begin
            n_vec++;
            if ({req0_ready, req1_ready} !== (g ? 2'b01 : 2'b10)) begin
               n_err++;
               $display("FAIL rr_grant%0d: got %b expected %b", cyc / 3,
                        {req0_ready, req1_ready}, (g ? 2'b01 : 2'b10));
            end
         end
         if (cyc % 3 == 2) begin
            n_vec++;
            if ({rsp_valid, rsp_id, rsp_gt, rsp_lt} !== {1'b1, g, !g, g}) begin
               n_err++;
               $display("FAIL rr_rsp%0d valid/id/gt/lt: got %b expected %b", cyc / 3,
                        {rsp_valid, rsp_id, rsp_gt, rsp_lt}, {1'b1, g, !g, g});
            end
         end
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd9; req0_signed = 1'b0;
      rsp_ready = 1'b0;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_accept: got %b expected 1", req0_ready);
      end
      step();
      req0_valid = 1'b0;
      step();
      req0_valid = 1'b1; req1_valid = 1'b1; req1_a = 16'd2; req1_b = 16'd2;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++;
         if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, req0_ready, req1_ready} !== 7'b1001000) begin
            n_err++;
            $display("FAIL bp_hold%0d: got %b expected 1001000", i,
                     {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, req0_ready, req1_ready});
         end
         step();
      end
      rsp_ready = 1'b1;
      #1;
      n_vec++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin
         n_err++;
         $display("FAIL bp_release_cycle: got %b expected 100", {rsp_valid, req0_ready, req1_ready});
      end
      step();
      n_vec++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL bp_next_grant: got %b expected 001", {rsp_valid, req0_ready, req1_ready});
      end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_eq} !== 3'b111) begin
         n_err++; $display("FAIL bp_second_rsp: got %b expected 111", {rsp_valid, rsp_id, rsp_eq});
      end
      step();
   endtask

   task automatic test_flush();
      logic acc, found; logic [3:0] fl; int lat;
      flush = 1'b1; req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd2;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         n_err++; $display("FAIL flush_idle_ready: got %b expected 00", {req0_ready, req1_ready});
      end
      step();
      flush = 1'b0;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1) begin
         n_err++; $display("FAIL flush_idle_release: got %b expected 1", req0_ready);
      end
      step();
      req0_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_eval_drop%0d: got %b expected 0", i, rsp_valid);
         end
         step();
      end
      req0_valid = 1'b1;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1) begin
         n_err++; $display("FAIL flush_reaccept: got %b expected 1", req0_ready);
      end
      step();
      req0_valid = 1'b0;
      step();
      n_vec++;
      if (rsp_valid !== 1'b1) begin
         n_err++; $display("FAIL flush_resp_reached: got %b expected 1", rsp_valid);
      end
      flush = 1'b1; rsp_ready = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_resp_drop%0d: got %b expected 0", i, rsp_valid);
         end
         step();
      end
      issue(1'b1, 16'd100, 16'd100, 1'b0, acc, found, fl, lat);
      n_vec++;
      if ({acc, found, fl, lat[3:0]} !== {2'b11, 4'b1001, 4'd2}) begin
         n_err++;
         $display("FAIL flush_recover acc/found/flags/lat: got %b expected %b",
                  {acc, found, fl, lat[3:0]}, {2'b11, 4'b1001, 4'd2});
      end
   endtask

   task automatic test_async_reset();
      req0_valid = 1'b1; req0_a = 16'd9; req0_b = 16'd3;
      req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd4;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_err++; $display("FAIL ar_pre_grant: got %b expected 10", {req0_ready, req1_ready});
      end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq} !== 7'b0) begin
         n_err++;
         $display("FAIL ar_outputs: got %b expected 0000000",
                  {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq});
      end
      step();
      reset_n = 1'b1;
      step();
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL ar_no_partial: got %b expected 0", rsp_valid);
      end
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_err++; $display("FAIL ar_first_grant: got %b expected 10", {req0_ready, req1_ready});
      end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_gt} !== 3'b101) begin
         n_err++; $display("FAIL ar_post_rsp: got %b expected 101", {rsp_valid, rsp_id, rsp_gt});
      end
      step();
   endtask

   initial begin
      clear_inputs();
      reset_n = 1'b1;
      #2;
      test_reset();
      test_single_port0();
      test_single_port1();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
